// File: rtl/joystick_cmd_gen.sv
// Joystick command generator: direction levels and fire pulses become queued game commands.
// Build option JOYSTICK_REPEAT_EN enables auto-repeat of held directions.
module joystick_cmd_gen #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int FIRE_COOLDOWN = 10_000_000,
    parameter int DEPTH         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_up,
    input  logic                   i_down,
    input  logic                   i_left,
    input  logic                   i_right,
    input  logic                   i_fire,
    output logic                   o_cmd_valid,
    output logic [2:0]             o_cmd,
    input  logic                   i_cmd_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CLW = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    // Loaded one short so that a fire exactly FIRE_COOLDOWN cycles later is accepted.
    localparam logic [CLW-1:0] COOL_LOAD = CLW'(FIRE_COOLDOWN - 1);

    localparam logic [2:0] CMD_UP    = 3'd0;
    localparam logic [2:0] CMD_DOWN  = 3'd1;
    localparam logic [2:0] CMD_LEFT  = 3'd2;
    localparam logic [2:0] CMD_RIGHT = 3'd3;
    localparam logic [2:0] CMD_FIRE  = 3'd4;

`ifdef JOYSTICK_REPEAT_EN
    localparam int MAXR = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(MAXR);
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    logic unused_cfg_s;
    assign unused_cfg_s = (REPEAT_DELAY >= 2) ^ (REPEAT_PERIOD >= 2);
`endif

    state_t          state_r;
    state_t          state_n;
    logic [2:0]      latched_r;
    logic [2:0]      latched_n;
    logic [CLW-1:0]  cool_r;
    logic [CLW-1:0]  cool_n;
    logic [2:0]      dir_s;
    logic            dir_valid_s;
    logic            step_s;
    logic [2:0]      step_cmd_s;
    logic            fire_s;

    logic [2:0]      mem_r [DEPTH];
    logic [2:0]      mem_n [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   wr_ptr_n;
    logic [AW-1:0]   wr_ptr_p1_s;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   rd_ptr_n;
    logic [AW:0]     count_n;
    logic [AW:0]     free_s;
    logic            pop_s;
    logic            push0_s;
    logic            push1_s;
    logic            drop_s;
    logic [2:0]      d0_s;
    logic [2:0]      d1_s;

    // Fixed-priority active direction over the held levels
    always_comb begin
        dir_valid_s = 1'b1;
        dir_s       = CMD_UP;
        if (i_up) begin
            dir_s = CMD_UP;
        end else if (i_down) begin
            dir_s = CMD_DOWN;
        end else if (i_left) begin
            dir_s = CMD_LEFT;
        end else if (i_right) begin
            dir_s = CMD_RIGHT;
        end else begin
            dir_valid_s = 1'b0;
        end
    end

    // Fire acceptance and cooldown countdown
    always_comb begin
        fire_s = 1'b0;
        cool_n = cool_r;
        if (i_fire && (cool_r == '0)) begin
            fire_s = 1'b1;
            cool_n = COOL_LOAD;
        end else if (cool_r != '0) begin
            cool_n = cool_r - CLW'(1);
        end else begin
            cool_n = cool_r;
        end
    end

    // Direction FSM next state and step emission
    always_comb begin
        state_n    = state_r;
        latched_n  = latched_r;
        step_s     = 1'b0;
        step_cmd_s = dir_s;
`ifdef JOYSTICK_REPEAT_EN
        cnt_n      = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (dir_valid_s) begin
                    step_s    = 1'b1;
                    latched_n = dir_s;
                    cnt_n     = DELAY_LOAD;
                    state_n   = ST_DELAY;
                end else begin
                    cnt_n = '0;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!dir_valid_s) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if (dir_s != latched_r) begin
                    step_s    = 1'b1;
                    latched_n = dir_s;
                    cnt_n     = DELAY_LOAD;
                    state_n   = ST_DELAY;
                end else if (cnt_r == '0) begin
                    step_s  = 1'b1;
                    cnt_n   = PERIOD_LOAD;
                    state_n = ST_REPEAT;
                end else begin
                    cnt_n = cnt_r - CW'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
`else
        case (state_r)
            ST_IDLE: begin
                if (dir_valid_s) begin
                    step_s    = 1'b1;
                    latched_n = dir_s;
                    state_n   = ST_HELD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (!dir_valid_s) begin
                    state_n = ST_IDLE;
                end else if (dir_s != latched_r) begin
                    step_s    = 1'b1;
                    latched_n = dir_s;
                end else begin
                    state_n = ST_HELD;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
`endif
    end

    // Direction FSM, latched direction and fire cooldown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            latched_r <= CMD_UP;
            cool_r    <= '0;
`ifdef JOYSTICK_REPEAT_EN
            cnt_r     <= '0;
`endif
        end else begin
            state_r   <= state_n;
            latched_r <= latched_n;
            cool_r    <= cool_n;
`ifdef JOYSTICK_REPEAT_EN
            cnt_r     <= cnt_n;
`endif
        end
    end

    assign wr_ptr_p1_s = wr_ptr_r + AW'(1);

    // FIFO write arbitration (FIRE older than step) and pointer/count update
    always_comb begin
        mem_n    = mem_r;
        drop_s   = 1'b0;
        push0_s  = 1'b0;
        push1_s  = 1'b0;
        d0_s     = CMD_FIRE;
        d1_s     = step_cmd_s;
        pop_s    = o_cmd_valid & i_cmd_ready;
        free_s   = (AW+1)'(DEPTH) - o_count + (AW+1)'(pop_s);
        if (fire_s && step_s) begin
            if (free_s >= (AW+1)'(2)) begin
                push0_s = 1'b1;
                push1_s = 1'b1;
            end else if (free_s == (AW+1)'(1)) begin
                push0_s = 1'b1;
                drop_s  = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (fire_s || step_s) begin
            d0_s = fire_s ? CMD_FIRE : step_cmd_s;
            if (free_s != '0) begin
                push0_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            drop_s = 1'b0;
        end
        if (push0_s) begin
            mem_n[wr_ptr_r] = d0_s;
        end else begin
            mem_n[wr_ptr_r] = mem_r[wr_ptr_r];
        end
        if (push1_s) begin
            mem_n[wr_ptr_p1_s] = d1_s;
        end else begin
            mem_n[wr_ptr_p1_s] = mem_n[wr_ptr_p1_s];
        end
        wr_ptr_n = wr_ptr_r + AW'(push0_s) + AW'(push1_s);
        rd_ptr_n = rd_ptr_r + AW'(pop_s);
        count_n  = o_count + (AW+1)'(push0_s) + (AW+1)'(push1_s) - (AW+1)'(pop_s);
    end

    // FIFO storage and registered head/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 3'd0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            o_count     <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd       <= 3'd0;
            o_overflow  <= 1'b0;
        end else begin
            mem_r       <= mem_n;
            wr_ptr_r    <= wr_ptr_n;
            rd_ptr_r    <= rd_ptr_n;
            o_count     <= count_n;
            o_cmd_valid <= (count_n != '0);
            o_cmd       <= (count_n != '0) ? mem_n[rd_ptr_n] : 3'd0;
            o_overflow  <= o_overflow | drop_s;
        end
    end

endmodule

// File: tb/tb_joystick_cmd_gen.sv
// Testbench for joystick_cmd_gen: constant-table sequences, directed corner cases and
// randomized traffic compared against a queue-based reference model.
module tb_joystick_cmd_gen;
    localparam int RD    = 8;
    localparam int RP    = 4;
    localparam int FC    = 6;
    localparam int DEPTH = 4;
`ifdef JOYSTICK_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_up = 1'b0;
    logic       i_down = 1'b0;
    logic       i_left = 1'b0;
    logic       i_right = 1'b0;
    logic       i_fire = 1'b0;
    logic       i_cmd_ready = 1'b0;
    logic       o_cmd_valid;
    logic [2:0] o_cmd;
    logic [2:0] o_count;
    logic       o_overflow;

    int checks = 0;
    int errors = 0;

    joystick_cmd_gen #(
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .FIRE_COOLDOWN(FC),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_up       (i_up),
        .i_down     (i_down),
        .i_left     (i_left),
        .i_right    (i_right),
        .i_fire     (i_fire),
        .o_cmd_valid(o_cmd_valid),
        .o_cmd      (o_cmd),
        .i_cmd_ready(i_cmd_ready),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: command queue, hold age of the active direction, time of last fire.
    int q[$];
    bit m_ovf;
    int m_hold;
    int m_age;
    bit m_fired;
    int m_last_fire;
    int m_cyc;

    function automatic void model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_hold  = -1;
        m_age   = 0;
        m_fired = 1'b0;
        m_cyc   = 0;
    endfunction

    function automatic int active_dir();
        if (i_up)    return 0;
        if (i_down)  return 1;
        if (i_left)  return 2;
        if (i_right) return 3;
        return -1;
    endfunction

    function automatic void model_push(int cmd);
        if (q.size() < DEPTH) q.push_back(cmd);
        else m_ovf = 1'b1;
    endfunction

    function automatic void model_step();
        int  d;
        bit  fire_ok;
        bit  step;
        if ((q.size() != 0) && i_cmd_ready) void'(q.pop_front());
        fire_ok = i_fire && (!m_fired || (m_cyc - m_last_fire) >= FC);
        if (fire_ok) begin
            m_fired     = 1'b1;
            m_last_fire = m_cyc;
        end
        d    = active_dir();
        step = 1'b0;
        if (d < 0) begin
            m_hold = -1;
        end else if (d != m_hold) begin
            step   = 1'b1;
            m_hold = d;
            m_age  = 0;
        end else begin
            m_age++;
            if (REP_EN && (m_age == RD || (m_age > RD && ((m_age - RD) % RP) == 0)))
                step = 1'b1;
        end
        if (fire_ok) model_push(4);
        if (step) model_push(d);
        m_cyc++;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_valid", int'(o_cmd_valid), int'(q.size() != 0));
        check("model_cmd", int'(o_cmd), (q.size() != 0) ? q[0] : 0);
        check("model_count", int'(o_count), q.size());
        check("model_ovf", int'(o_overflow), int'(m_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        check("rst_valid", int'(o_cmd_valid), 0);
        check("rst_count", int'(o_count), 0);
        check("rst_ovf", int'(o_overflow), 0);
        check("rst_cmd", int'(o_cmd), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_dirs(input logic u, input logic d, input logic l, input logic r);
        i_up = u; i_down = d; i_left = l; i_right = r;
    endtask

    typedef struct {
        logic       ready;
        logic       fire;
        logic [3:0] dirs;     // {up, down, left, right}
        int         exp_count;
        logic       exp_valid;
        logic [2:0] exp_cmd;
        logic       exp_ovf;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic f, logic [3:0] dr, int c, logic v,
                                logic [2:0] cm, logic ov);
        vec_t t;
        t.ready = rdy; t.fire = f; t.dirs = dr; t.exp_count = c;
        t.exp_valid = v; t.exp_cmd = cm; t.exp_ovf = ov;
        return t;
    endfunction

    vec_t tbl[18];

    initial begin
        int bias;
        tbl[0]  = mk(1'b0, 1'b1, 4'b0000, 1, 1'b1, 3'd4, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 4'b0000, 1, 1'b1, 3'd4, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 4'b0000, 1, 1'b1, 3'd4, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 4'b0000, 1, 1'b1, 3'd4, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 4'b0000, 1, 1'b1, 3'd4, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 4'b0000, 1, 1'b1, 3'd4, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 4'b0000, 2, 1'b1, 3'd4, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 4'b0100, 3, 1'b1, 3'd4, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 4'b0000, 3, 1'b1, 3'd4, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 4'b0000, 3, 1'b1, 3'd4, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 4'b0000, 3, 1'b1, 3'd4, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 4'b0000, 3, 1'b1, 3'd4, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 4'b0010, 4, 1'b1, 3'd4, 1'b1);
        tbl[13] = mk(1'b1, 1'b0, 4'b0010, 3, 1'b1, 3'd4, 1'b1);
        tbl[14] = mk(1'b1, 1'b0, 4'b0000, 2, 1'b1, 3'd1, 1'b1);
        tbl[15] = mk(1'b1, 1'b0, 4'b0001, 2, 1'b1, 3'd4, 1'b1);
        tbl[16] = mk(1'b1, 1'b0, 4'b0000, 1, 1'b1, 3'd3, 1'b1);
        tbl[17] = mk(1'b1, 1'b0, 4'b0000, 0, 1'b0, 3'd0, 1'b1);

        #1;
        apply_reset();

        // Fire cooldown, same-cycle fire+step overflow, drain order.
        for (int i = 0; i < 18; i++) begin
            i_cmd_ready = tbl[i].ready;
            i_fire      = tbl[i].fire;
            set_dirs(tbl[i].dirs[3], tbl[i].dirs[2], tbl[i].dirs[1], tbl[i].dirs[0]);
            tick();
            check("tbl_count", int'(o_count), tbl[i].exp_count);
            check("tbl_valid", int'(o_cmd_valid), int'(tbl[i].exp_valid));
            check("tbl_cmd", int'(o_cmd), int'(tbl[i].exp_cmd));
            check("tbl_ovf", int'(o_overflow), int'(tbl[i].exp_ovf));
        end
        i_fire = 1'b0;

        // Reset in the middle of a hold with entries queued and overflow set.
        i_cmd_ready = 1'b0;
        set_dirs(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        apply_reset();
        tick();
        check("post_rst_valid", int'(o_cmd_valid), 1);
        check("post_rst_cmd", int'(o_cmd), 0);
        check("post_rst_count", int'(o_count), 1);

        // Hold UP for 20 cycles with the consumer always ready.
        set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset();
        i_cmd_ready = 1'b1;
        set_dirs(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_up_valid", int'(o_cmd_valid),
                  int'((i == 0) || (REP_EN && (i == 8 || i == 12 || i == 16))));
        end
        set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("release_valid", int'(o_cmd_valid), 0);
        end

        // Hold LEFT, then press UP while LEFT stays held.
        set_dirs(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        set_dirs(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("up_over_left_valid", int'(o_cmd_valid), 1);
        check("up_over_left_cmd", int'(o_cmd), 0);
        tick();
        set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Full FIFO, ready and a new step in the same cycle: pop plus push, no overflow.
        apply_reset();
        i_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_dirs(i == 0, i == 1, i == 2, i == 3);
            tick();
            set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check("full_count", int'(o_count), 4);
        i_cmd_ready = 1'b1;
        set_dirs(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("pop_push_count", int'(o_count), 4);
        check("pop_push_ovf", int'(o_overflow), 0);
        check("pop_push_head", int'(o_cmd), 1);
        set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
        i_cmd_ready = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bias = (n < 1000) ? 70 : ((n < 2000) ? 25 : 90);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 5) < 2)
                    set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
                else
                    {i_up, i_down, i_left, i_right} = 4'($urandom_range(1, 15));
            end
            i_fire      = ($urandom_range(0, 4) == 0);
            i_cmd_ready = ($urandom_range(0, 99) < bias);
            if ($urandom_range(0, 599) == 0) apply_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
